router_req_arbiter: RTL and testbench
=====================================

# router_req_arbiter

Two-requester round-robin arbiter that shares the single address/data router input between two masters. It accepts one transfer at a time through a valid/ready handshake and re-issues it to the router as an isolated one-clock valid pulse. It enforces a programmable idle gap between pulses and keeps saturating per-destination transfer counters (port A region 0x00–0x3F, port B region 0x40–0xFF). It sits directly in front of the router's valid/addr_in/data_in inputs.

## Interface
- GAP_CYCLES, 1, idle cycles inserted after each router pulse before the next grant (legal 0..15)
- clk  input  1  100 MHz clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = grants allowed; 0 = no new grants, in-flight pulse completes
- r0_valid  input  1  requester 0 has a transfer pending
- r0_addr  input  8  requester 0 address
- r0_data  input  16  requester 0 data
- r0_ready  output  1  requester 0 transfer accepted this cycle
- r1_valid, r1_addr, r1_data, r1_ready: same as requester 0, for requester 1
- out_valid  output  1  router valid, one-clock pulse
- out_addr  output  8  router addr_in
- out_data  output  16  router data_in
- out_src  output  1  requester index of the current pulse
- busy  output  1  state is not IDLE
- count_a  output  16  saturating count of issued transfers with addr <= 0x3F
- count_b  output  16  saturating count of issued transfers with addr >= 0x40

## Operation
- FSM states: IDLE, ISSUE, GAP.
- IDLE: if enable=1 and any rX_valid=1, grant one requester.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the requester not granted last wins.
  - Pointer last_grant updates to the winner. Reset value is 1, so r0 wins the first contention.
- rX_ready is combinational: (state==IDLE) && enable && grant_X. At most one ready is high per cycle.
- A transfer occurs on the edge where rX_valid && rX_ready.
  - On that edge, addr/data/index are captured into out_addr/out_data/out_src.
  - The FSM moves to ISSUE.
  - Requesters hold valid/addr/data stable until ready. Dropping valid before ready withdraws the request; this is legal.
- ISSUE (exactly 1 cycle): out_valid=1.
  - On exit, increment count_a if out_addr <= 0x3F, else count_b. Each counter saturates at 0xFFFF.
  - Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: a 4-bit down-counter loaded with GAP_CYCLES on ISSUE exit. Stay in GAP until it has spent GAP_CYCLES cycles there, then go to IDLE.
- Outside ISSUE, out_valid=0, out_addr=0, out_data=0, out_src=0.
- enable only gates grants in IDLE. Deasserting it in ISSUE or GAP does not abort the sequence.

## Timing
- Reset values (cycle after reset sampled high):
  - state=IDLE, last_grant=1, gap counter=0.
  - All outputs 0: out_valid, out_addr, out_data, out_src, busy, count_a, count_b, r0_ready, r1_ready.
  - Note: rX_ready is combinational, so it goes high in the first IDLE cycle with reset=0, enable=1 and rX_valid=1.
- Latency: ready seen in cycle t gives out_valid=1 in cycle t+1. The counter updates are visible in cycle t+2.
- Issue period: 2 + GAP_CYCLES cycles per transfer under continuous requests. With GAP_CYCLES=0, pulses are separated by 1 low cycle, so router valid is never high two cycles in a row.
- Reset mid-operation (ISSUE or GAP): the next cycle shows reset values. The in-flight pulse is dropped and not counted. The pointer returns to 1.
- Simultaneous valids plus enable rising in the same cycle: a grant is issued that cycle.
- Boundary addresses: 0x3F counts to A, 0x40 counts to B, 0x00 to A, 0xFF to B.

## Test plan
- Reset: hold reset 2 cycles with both valids high.
  - During reset, all registered outputs are 0 and the FSM is held in IDLE.
  - First cycle after release (enable=1): r0_ready=1.
- Single transfer, GAP_CYCLES=1: r0 sends addr 0x10, data 0xBEEF.
  - r0_ready in cycle 0.
  - Cycle 1: out_valid=1, out_addr=0x10, out_data=0xBEEF, out_src=0.
  - Cycle 2: out_valid=0, busy=1, count_a=1.
  - Cycle 3: IDLE.
- Contention, GAP_CYCLES=1: both valid continuously, r0 addr 0x20/data 0x1111, r1 addr 0x80/data 0x2222.
  - Grants alternate r0, r1, r0, r1 every 3 cycles.
  - After 4 pulses, count_a=2 and count_b=2.
- Address boundary: issue 0x3F then 0x40 → count_a=1, count_b=1.
- Enable gating: enable=0 with r1_valid high for 5 cycles → no ready and no pulse.
  - Raise enable → r1_ready the same cycle.
  - Drop enable during ISSUE → the pulse still completes.
- Reset during ISSUE: assert reset in the pulse cycle.
  - Next cycle: out_valid=0 and counters 0.
  - After release with both valid, r0 is granted first.

Source files
------------

// File: rtl/router_req_arbiter_if.sv
// Requester-side and router-side handshake signals of the two-master request arbiter.
interface router_req_arbiter_if;
    logic        r0_valid;
    logic [7:0]  r0_addr;
    logic [15:0] r0_data;
    logic        r0_ready;
    logic        r1_valid;
    logic [7:0]  r1_addr;
    logic [15:0] r1_data;
    logic        r1_ready;
    logic        out_valid;
    logic [7:0]  out_addr;
    logic [15:0] out_data;
    logic        out_src;

    modport master (
        output r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
        input  r0_ready, r1_ready, out_valid, out_addr, out_data, out_src
    );

    modport slave (
        input  r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
        output r0_ready, r1_ready, out_valid, out_addr, out_data, out_src
    );
endinterface

// File: rtl/router_req_arbiter.sv
// Two-requester round-robin arbiter feeding the router as isolated one-clock valid
// pulses, with a programmable idle gap and saturating per-region transfer counters.
module router_req_arbiter #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    router_req_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [15:0]          count_a,
    output logic [15:0]          count_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_grant0;
    logic        w_grant1;
    logic        r_last_grant;
    logic [3:0]  r_gap_cnt;
    logic        r_busy;
    logic        r_out_valid;
    logic [7:0]  r_out_addr;
    logic [15:0] r_out_data;
    logic        r_out_src;
    logic [15:0] r_count_a;
    logic [15:0] r_count_b;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Grant decision and next-state selection
    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On contention the requester not granted last time wins
                if (enable && !reset) begin
                    w_grant0 = bus.r0_valid && (!bus.r1_valid || r_last_grant);
                    w_grant1 = bus.r1_valid && (!bus.r0_valid || !r_last_grant);
                end else begin
                    w_grant0 = 1'b0;
                    w_grant1 = 1'b0;
                end
                if (w_grant0 || w_grant1) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (GAP_LOAD != 4'd0) begin
                    w_next_state = ST_GAP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    // Transfer capture, router pulse, gap countdown and region counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_gap_cnt    <= 4'd0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= 8'h00;
            r_out_data   <= 16'h0000;
            r_out_src    <= 1'b0;
            r_count_a    <= 16'h0000;
            r_count_b    <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0) begin
                        r_out_valid  <= 1'b1;
                        r_out_addr   <= bus.r0_addr;
                        r_out_data   <= bus.r0_data;
                        r_out_src    <= 1'b0;
                        r_last_grant <= 1'b0;
                    end else if (w_grant1) begin
                        r_out_valid  <= 1'b1;
                        r_out_addr   <= bus.r1_addr;
                        r_out_data   <= bus.r1_data;
                        r_out_src    <= 1'b1;
                        r_last_grant <= 1'b1;
                    end else begin
                        r_out_valid  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_out_valid <= 1'b0;
                    r_out_addr  <= 8'h00;
                    r_out_data  <= 16'h0000;
                    r_out_src   <= 1'b0;
                    r_gap_cnt   <= GAP_LOAD;
                    if (r_out_addr <= 8'h3F) begin
                        r_count_a <= sat_inc(r_count_a);
                    end else begin
                        r_count_b <= sat_inc(r_count_b);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end else begin
                        r_gap_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_gap_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.r0_ready  = w_grant0;
    assign bus.r1_ready  = w_grant1;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign busy          = r_busy;
    assign count_a       = r_count_a;
    assign count_b       = r_count_b;

endmodule

// File: tb/tb_router_req_arbiter.sv
// Directed-vector bench for router_req_arbiter: a GAP_CYCLES=1 instance driven from a
// per-cycle table and a GAP_CYCLES=0 instance exercised by a hand-written sequence.
module tb_router_req_arbiter;

    typedef struct {
        logic        rst;
        logic        en;
        logic        v0;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic        rr0;
        logic        rr1;
        logic        ov;
        logic [7:0]  oa;
        logic [15:0] od;
        logic        os;
        logic        bsy;
        logic [15:0] ca;
        logic [15:0] cb;
    } vec_t;

    localparam logic [7:0]  A0 = 8'h20;
    localparam logic [15:0] D0 = 16'h1111;
    localparam logic [7:0]  A1 = 8'h80;
    localparam logic [15:0] D1 = 16'h2222;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        en_g0;
    logic        busy;
    logic [15:0] count_a;
    logic [15:0] count_b;
    logic        busy_g0;
    logic [15:0] count_a_g0;
    logic [15:0] count_b_g0;
    int          n_checks;
    int          n_errors;
    vec_t        vecs[$];

    router_req_arbiter_if bus1();
    router_req_arbiter_if bus0();

    router_req_arbiter #(.GAP_CYCLES(1)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bus     (bus1),
        .busy    (busy),
        .count_a (count_a),
        .count_b (count_b)
    );

    router_req_arbiter #(.GAP_CYCLES(0)) u_dut_g0 (
        .clk     (clk),
        .reset   (reset),
        .enable  (en_g0),
        .bus     (bus0),
        .busy    (busy_g0),
        .count_a (count_a_g0),
        .count_b (count_b_g0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst, input logic en,
        input logic v0, input logic [7:0] a0, input logic [15:0] d0,
        input logic v1, input logic [7:0] a1, input logic [15:0] d1,
        input logic rr0, input logic rr1, input logic ov, input logic [7:0] oa,
        input logic [15:0] od, input logic os, input logic bsy,
        input logic [15:0] ca, input logic [15:0] cb);
        vec_t v;
        v.rst = rst; v.en = en;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.rr0 = rr0; v.rr1 = rr1; v.ov = ov; v.oa = oa; v.od = od;
        v.os = os; v.bsy = bsy; v.ca = ca; v.cb = cb;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; enable = 1'b1; en_g0 = 1'b0;
        bus1.r0_valid = 1'b0; bus1.r0_addr = 8'h00; bus1.r0_data = 16'h0000;
        bus1.r1_valid = 1'b0; bus1.r1_addr = 8'h00; bus1.r1_data = 16'h0000;
        bus0.r0_valid = 1'b0; bus0.r0_addr = 8'h00; bus0.r0_data = 16'h0000;
        bus0.r1_valid = 1'b0; bus0.r1_addr = 8'h00; bus0.r1_data = 16'h0000;

        //              rst   en    v0  a0     d0        v1  a1     d1       rr0   rr1   ov    oa     od         os    bsy   ca      cb
        vecs.push_back(mk(1'b1,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd0,16'd0));
        vecs.push_back(mk(1'b1,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd0,16'd0));
        // contention: r0, r1, r0, r1 every three cycles
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd0,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b1,A0,   D0,      1'b0,1'b1,16'd0,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd1,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd1,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b1,A1,   D1,      1'b1,1'b1,16'd1,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd1,16'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd1,16'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b1,A0,   D0,      1'b0,1'b1,16'd1,16'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd2,16'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd2,16'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b0,1'b0,1'b1,A1,   D1,      1'b1,1'b1,16'd2,16'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd2,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd2,16'd2));
        // single transfer 0x10 / 0xBEEF
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'h10,16'hBEEF,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd2,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'h10,16'hBEEF,1'b0,1'b1,16'd2,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd3,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd3,16'd2));
        // address boundaries 0x3F, 0x40, 0x00, 0xFF
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'h3F,16'h0001,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd3,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'h3F,16'h0001,1'b0,1'b1,16'd3,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd4,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b1,8'h40,16'h0002,1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd4,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'h40,16'h0002,1'b1,1'b1,16'd4,16'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd4,16'd3));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'h00,16'h0003,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd4,16'd3));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'h00,16'h0003,1'b0,1'b1,16'd4,16'd3));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd5,16'd3));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b1,8'hFF,16'h0004,1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd5,16'd3));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'hFF,16'h0004,1'b1,1'b1,16'd5,16'd3));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd5,16'd4));
        // enable gating: five cycles held off, then a same-cycle grant, then enable dropped in ISSUE
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,16'h0000,1'b1,8'h81,16'h5555,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd5,16'd4));
        end
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b1,8'h81,16'h5555,1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd5,16'd4));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'h81,16'h5555,1'b1,1'b1,16'd5,16'd4));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd5,16'd5));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd5,16'd5));
        // reset asserted in the pulse cycle drops the pulse and restores the pointer
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'h05,16'h0006,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd5,16'd5));
        vecs.push_back(mk(1'b1,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'h05,16'h0006,1'b0,1'b1,16'd5,16'd5));
        vecs.push_back(mk(1'b0,1'b1,1'b1,A0,   D0,      1'b1,A1,   D1,      1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd0,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,A0,   D0,      1'b0,1'b1,16'd0,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd1,16'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'h00,16'h0000,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,16'd1,16'd0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            enable = vecs[i].en;
            bus1.r0_valid = vecs[i].v0; bus1.r0_addr = vecs[i].a0; bus1.r0_data = vecs[i].d0;
            bus1.r1_valid = vecs[i].v1; bus1.r1_addr = vecs[i].a1; bus1.r1_data = vecs[i].d1;
            @(negedge clk);
            chk("r0_ready",  i, 16'(bus1.r0_ready),  16'(vecs[i].rr0));
            chk("r1_ready",  i, 16'(bus1.r1_ready),  16'(vecs[i].rr1));
            chk("out_valid", i, 16'(bus1.out_valid), 16'(vecs[i].ov));
            chk("out_addr",  i, 16'(bus1.out_addr),  16'(vecs[i].oa));
            chk("out_data",  i, bus1.out_data,       vecs[i].od);
            chk("out_src",   i, 16'(bus1.out_src),   16'(vecs[i].os));
            chk("busy",      i, 16'(busy),           16'(vecs[i].bsy));
            chk("count_a",   i, count_a,             vecs[i].ca);
            chk("count_b",   i, count_b,             vecs[i].cb);
            @(posedge clk);
            #1;
        end

        // zero-gap instance: pulses every other cycle, never back to back
        en_g0 = 1'b1;
        bus0.r0_valid = 1'b1; bus0.r0_addr = 8'h11; bus0.r0_data = 16'h0A0A;
        bus0.r1_valid = 1'b1; bus0.r1_addr = 8'h91; bus0.r1_data = 16'h0B0B;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("g0_r0_ready",  k, 16'(bus0.r0_ready),  (k % 4 == 0) ? 16'd1 : 16'd0);
            chk("g0_r1_ready",  k, 16'(bus0.r1_ready),  (k % 4 == 2) ? 16'd1 : 16'd0);
            chk("g0_out_valid", k, 16'(bus0.out_valid), (k % 2 == 1) ? 16'd1 : 16'd0);
            chk("g0_out_src",   k, 16'(bus0.out_src),   (k % 4 == 3) ? 16'd1 : 16'd0);
            chk("g0_busy",      k, 16'(busy_g0),        (k % 2 == 1) ? 16'd1 : 16'd0);
            @(posedge clk);
            #1;
        end
        bus0.r0_valid = 1'b0;
        bus0.r1_valid = 1'b0;
        @(negedge clk);
        chk("g0_count_a", 8, count_a_g0, 16'd2);
        chk("g0_count_b", 8, count_b_g0, 16'd2);
        chk("g0_out_valid_end", 8, 16'(bus0.out_valid), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
